// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage_if
// Purpose  : EX->MEM handshake and payload bundle, including flush and the
//            stall counter readback.
// Revision : 1.0
// ============================================================================
interface ex_mem_stage_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              i_valid;
    logic              i_ready;
    logic [XLEN-1:0]   i_pc4;
    logic [XLEN-1:0]   i_imme;
    logic [XLEN-1:0]   i_pc_imm;
    logic [XLEN-1:0]   i_aluout;
    logic [XLEN-1:0]   i_wr_mem_data;
    logic [REG_AW-1:0] i_Rd;
    logic [REG_AW-1:0] i_Rs2;
    logic [CTRL_W-1:0] i_ctrl;
    logic              o_valid;
    logic              o_ready;
    logic [XLEN-1:0]   o_pc4;
    logic [XLEN-1:0]   o_imme;
    logic [XLEN-1:0]   o_pc_imm;
    logic [XLEN-1:0]   o_aluout;
    logic [XLEN-1:0]   o_wr_mem_data;
    logic [REG_AW-1:0] o_Rd;
    logic [REG_AW-1:0] o_Rs2;
    logic [CTRL_W-1:0] o_ctrl;
    logic [CNT_W-1:0]  o_stall_cnt;

    modport master (
        output flush, i_valid, i_pc4, i_imme, i_pc_imm, i_aluout, i_wr_mem_data,
               i_Rd, i_Rs2, i_ctrl, o_ready,
        input  i_ready, o_valid, o_pc4, o_imme, o_pc_imm, o_aluout, o_wr_mem_data,
               o_Rd, o_Rs2, o_ctrl, o_stall_cnt
    );

    modport slave (
        input  flush, i_valid, i_pc4, i_imme, i_pc_imm, i_aluout, i_wr_mem_data,
               i_Rd, i_Rs2, i_ctrl, o_ready,
        output i_ready, o_valid, o_pc4, o_imme, o_pc_imm, o_aluout, o_wr_mem_data,
               o_Rd, o_Rs2, o_ctrl, o_stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX->MEM pipeline register with valid/ready, flush and saturating
//            back-pressure counter. Define EX_MEM_SKID_EN for a registered-ready
//            two-entry (skid) variant.
// Revision : 1.0
// ============================================================================
module ex_mem_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_mem_stage_if.slave bus
);
    localparam int               c_PAY_W   = 5*XLEN + 2*REG_AW + CTRL_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [c_PAY_W-1:0] w_in_pay;
    logic               r_valid_q, w_valid_d;
    logic [c_PAY_W-1:0] r_main_q,  w_main_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic               w_accept;
    logic               w_release;

    assign w_in_pay  = {bus.i_pc4, bus.i_imme, bus.i_pc_imm, bus.i_aluout,
                        bus.i_wr_mem_data, bus.i_Rd, bus.i_Rs2, bus.i_ctrl};
    assign w_release = r_valid_q && bus.o_ready;

`ifdef EX_MEM_SKID_EN
    logic               r_skid_valid_q, w_skid_valid_d;
    logic [c_PAY_W-1:0] r_skid_q,       w_skid_d;
    logic               r_ready_q,      w_ready_d;

    assign bus.i_ready = r_ready_q;
    assign w_accept    = bus.i_valid && r_ready_q;

    always_comb begin
        w_valid_d      = r_valid_q;
        w_main_d       = r_main_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_d       = r_skid_q;
        if (w_release) begin
            // Skid drains first; no accept is possible while it is occupied.
            if (r_skid_valid_q) begin
                w_main_d       = r_skid_q;
                w_skid_valid_d = 1'b0;
            end else if (w_accept) begin
                w_main_d = w_in_pay;
            end else begin
                w_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (r_valid_q) begin
                w_skid_d       = w_in_pay;
                w_skid_valid_d = 1'b1;
            end else begin
                w_main_d  = w_in_pay;
                w_valid_d = 1'b1;
            end
        end
        if (bus.flush) begin
            w_valid_d      = 1'b0;
            w_skid_valid_d = 1'b0;
            w_main_d       = r_main_q;
            w_skid_d       = r_skid_q;
        end
        w_ready_d = !w_skid_valid_d;
    end
`else
    assign bus.i_ready = !r_valid_q || bus.o_ready;
    assign w_accept    = bus.i_valid && bus.i_ready;

    always_comb begin
        w_valid_d = r_valid_q;
        w_main_d  = r_main_q;
        if (w_accept) begin
            w_main_d  = w_in_pay;
            w_valid_d = 1'b1;
        end else if (w_release) begin
            w_valid_d = 1'b0;
        end
        // A flushed accept still handshakes but its payload is dropped.
        if (bus.flush) begin
            w_valid_d = 1'b0;
            w_main_d  = r_main_q;
        end
    end
`endif

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (r_valid_q && !bus.o_ready && (r_cnt_q != c_CNT_MAX)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q      <= 1'b0;
            r_main_q       <= '0;
            r_cnt_q        <= '0;
`ifdef EX_MEM_SKID_EN
            r_skid_valid_q <= 1'b0;
            r_skid_q       <= '0;
            r_ready_q      <= 1'b1;
`endif
        end else begin
            r_valid_q      <= w_valid_d;
            r_main_q       <= w_main_d;
            r_cnt_q        <= w_cnt_d;
`ifdef EX_MEM_SKID_EN
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_q       <= w_skid_d;
            r_ready_q      <= w_ready_d;
`endif
        end
    end

    assign bus.o_valid     = r_valid_q;
    assign bus.o_stall_cnt = r_cnt_q;
    assign {bus.o_pc4, bus.o_imme, bus.o_pc_imm, bus.o_aluout,
            bus.o_wr_mem_data, bus.o_Rd, bus.o_Rs2, bus.o_ctrl} = r_main_q;
endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage: vector table, scoreboard
//            on every accept/release, and directed multi-cycle sequences.
// Revision : 1.0
// ============================================================================
module tb_ex_mem_stage;
    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int PW     = 5*XLEN + 2*REG_AW + CTRL_W;
`ifdef EX_MEM_SKID_EN
    localparam int EXTRA_ACC = 1;
`else
    localparam int EXTRA_ACC = 0;
`endif

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [63:0] alu;
        logic        ev;
        logic [63:0] ealu;
        logic [63:0] ecnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    logic [PW-1:0] sb[$];

    ex_mem_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus();

    ex_mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: releases pop and compare, accepts push (unless flushed).
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_valid && bus.o_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_release: got unexpected entry aluout=%0h, required no release", bus.o_aluout);
                end else begin
                    logic [PW-1:0] exp_p, act_p;
                    exp_p = sb.pop_front();
                    act_p = {bus.o_pc4, bus.o_imme, bus.o_pc_imm, bus.o_aluout,
                             bus.o_wr_mem_data, bus.o_Rd, bus.o_Rs2, bus.o_ctrl};
                    if (act_p !== exp_p) begin
                        n_fail++;
                        $display("FAIL sb_payload: got %0h required %0h", act_p, exp_p);
                    end
                end
            end
            if (bus.flush) begin
                sb.delete();
            end else if (bus.i_valid && bus.i_ready) begin
                sb.push_back({bus.i_pc4, bus.i_imme, bus.i_pc_imm, bus.i_aluout,
                              bus.i_wr_mem_data, bus.i_Rd, bus.i_Rs2, bus.i_ctrl});
                n_acc++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   acc0;
        vt[0] = '{1'b1, 1'b1, 64'd1, 1'b1, 64'd1, 64'd0};
        vt[1] = '{1'b1, 1'b1, 64'd2, 1'b1, 64'd2, 64'd0};
        vt[2] = '{1'b1, 1'b1, 64'd3, 1'b1, 64'd3, 64'd0};
        vt[3] = '{1'b1, 1'b1, 64'd4, 1'b1, 64'd4, 64'd0};
        vt[4] = '{1'b0, 1'b1, 64'd0, 1'b0, 64'd4, 64'd0};
        vt[5] = '{1'b1, 1'b0, 64'd7, 1'b1, 64'd7, 64'd0};
        vt[6] = '{1'b0, 1'b0, 64'd0, 1'b1, 64'd7, 64'd1};
        vt[7] = '{1'b0, 1'b1, 64'd0, 1'b0, 64'd7, 64'd1};

        bus.flush = 1'b0; bus.i_valid = 1'b0; bus.o_ready = 1'b0;
        bus.i_pc4 = '0; bus.i_imme = '0; bus.i_pc_imm = '0; bus.i_aluout = '0;
        bus.i_wr_mem_data = '0; bus.i_Rd = '0; bus.i_Rs2 = '0; bus.i_ctrl = '0;
        do_reset();

        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_aluout", bus.o_aluout, 64'd0);
        chk("rst_o_pc4", bus.o_pc4, 64'd0);
        chk("rst_o_ctrl", 64'(bus.o_ctrl), 64'd0);
        chk("rst_stall_cnt", 64'(bus.o_stall_cnt), 64'd0);
        chk("rst_i_ready", 64'(bus.i_ready), 64'd1);

        // Streaming and simple hold/drain vectors
        for (int i = 0; i < 8; i++) begin
            bus.i_valid  = vt[i].iv;
            bus.o_ready  = vt[i].ordy;
            bus.i_aluout = vt[i].alu;
            bus.i_pc4    = vt[i].alu + 64'd4;
            tick();
            chk($sformatf("vec%0d_o_valid", i), 64'(bus.o_valid), 64'(vt[i].ev));
            chk($sformatf("vec%0d_o_aluout", i), bus.o_aluout, vt[i].ealu);
            chk($sformatf("vec%0d_stall_cnt", i), 64'(bus.o_stall_cnt), vt[i].ecnt);
        end

        // Back-pressure with 0xA held, 0xB offered
        do_reset();
        bus.i_valid = 1'b1; bus.i_aluout = 64'hA; bus.o_ready = 1'b0;
        tick();
        chk("bp_first_valid", 64'(bus.o_valid), 64'd1);
        acc0 = n_acc;
        bus.i_aluout = 64'hB;
        repeat (3) tick();
        chk("bp_hold_aluout", bus.o_aluout, 64'hA);
        chk("bp_stall_cnt", 64'(bus.o_stall_cnt), 64'd3);
        chk("bp_i_ready", 64'(bus.i_ready), 64'd0);
        chk("bp_extra_accepts", 64'(n_acc - acc0), 64'(EXTRA_ACC));
        bus.i_valid = 1'b0; bus.o_ready = 1'b1;
        tick();
        chk("bp_drain1_valid", 64'(bus.o_valid), 64'(EXTRA_ACC));
        tick();
        chk("bp_drain2_valid", 64'(bus.o_valid), 64'd0);
        chk("bp_cnt_after", 64'(bus.o_stall_cnt), 64'd3);

        // Flush wins over a same-cycle accept; back-to-back flush; accept after
        do_reset();
        bus.i_valid = 1'b1; bus.i_aluout = 64'h3; bus.o_ready = 1'b0;
        tick();
        bus.flush = 1'b1; bus.i_aluout = 64'h5; bus.o_ready = 1'b1;
        #1;
        chk("fl_i_ready", 64'(bus.i_ready), 64'd1);
        tick();
        chk("fl_valid1", 64'(bus.o_valid), 64'd0);
        bus.i_aluout = 64'h8;
        tick();
        chk("fl_valid2", 64'(bus.o_valid), 64'd0);
        bus.flush = 1'b0; bus.i_aluout = 64'h6;
        tick();
        chk("fl_after_valid", 64'(bus.o_valid), 64'd1);
        chk("fl_after_aluout", bus.o_aluout, 64'h6);
        bus.i_valid = 1'b0;
        tick();
        chk("fl_drain_valid", 64'(bus.o_valid), 64'd0);

        // Counter saturation then asynchronous reset mid-stall
        do_reset();
        bus.i_valid = 1'b1; bus.i_aluout = 64'hC; bus.i_pc_imm = 64'h1234; bus.o_ready = 1'b0;
        tick();
        bus.i_valid = 1'b0;
        repeat (20) tick();
        chk("sat_stall_cnt", 64'(bus.o_stall_cnt), 64'd15);
        chk("sat_aluout", bus.o_aluout, 64'hC);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.o_valid), 64'd0);
        chk("arst_stall_cnt", 64'(bus.o_stall_cnt), 64'd0);
        chk("arst_aluout", bus.o_aluout, 64'd0);
        chk("arst_pc_imm", bus.o_pc_imm, 64'd0);
        chk("arst_i_ready", 64'(bus.i_ready), 64'd1);
        tick();
        sb.delete();
        rst_n = 1'b1;

        // Full-width payload
        bus.i_valid = 1'b1; bus.o_ready = 1'b1;
        bus.i_pc_imm = 64'hFFFF_FFFF_0000_0001; bus.i_Rd = 5'd31; bus.i_ctrl = 8'hA5;
        bus.i_pc4 = 64'h8000_0000_0000_0004; bus.i_imme = 64'hFFFF_FFFF_FFFF_FFF0;
        bus.i_wr_mem_data = 64'hDEAD_BEEF_CAFE_F00D; bus.i_Rs2 = 5'd17; bus.i_aluout = 64'h55;
        tick();
        chk("fw_pc_imm", bus.o_pc_imm, 64'hFFFF_FFFF_0000_0001);
        chk("fw_rd", 64'(bus.o_Rd), 64'd31);
        chk("fw_ctrl", 64'(bus.o_ctrl), 64'hA5);
        chk("fw_imme", bus.o_imme, 64'hFFFF_FFFF_FFFF_FFF0);
        bus.i_valid = 1'b0;
        tick();
        chk("fw_drain_valid", 64'(bus.o_valid), 64'd0);
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
